// File: rtl/trace_replay_pkg.sv
// Shared types and helpers for the trace replay driver.
package trace_replay_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_e;

    localparam int PASS_CNT_W = 16;

    function automatic logic [31:0] clamp_len(input logic [31:0] len_in, input logic [31:0] depth);
        if (len_in > depth) begin
            return depth;
        end else begin
            return len_in;
        end
    endfunction

endpackage

// File: rtl/trace_replay_mem.sv
// Trace storage: stimulus, expected and mask arrays sharing one write port
// and one registered read port returning {stim, exp, mask}.
module trace_replay_mem
    import trace_replay_pkg::*;
#(
    parameter int STIM_W = 8,
    parameter int CHK_W  = 8,
    parameter int DEPTH  = 16,
    parameter int CYC_W  = $clog2(DEPTH + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [CYC_W-1:0]            wr_addr,
    input  logic [STIM_W-1:0]           wr_stim,
    input  logic [CHK_W-1:0]            wr_exp,
    input  logic [CHK_W-1:0]            wr_mask,
    input  logic                        rd_en,
    input  logic [CYC_W-1:0]            rd_addr,
    output logic [STIM_W+2*CHK_W-1:0]   rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CYC_W-1:0] DEPTH_C = CYC_W'(DEPTH);

    logic [STIM_W-1:0]         stim_mem_q [DEPTH];
    logic [CHK_W-1:0]          exp_mem_q  [DEPTH];
    logic [CHK_W-1:0]          mask_mem_q [DEPTH];
    logic [STIM_W+2*CHK_W-1:0] rd_q;

    // Array contents survive reset; out-of-range addresses are dropped.
    always_ff @(posedge clock) begin
        if (wr_en && (wr_addr < DEPTH_C)) begin
            stim_mem_q[wr_addr[AW-1:0]] <= wr_stim;
            exp_mem_q[wr_addr[AW-1:0]]  <= wr_exp;
            mask_mem_q[wr_addr[AW-1:0]] <= wr_mask;
        end
    end

    // Read register holds its word whenever rd_en is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q <= {(STIM_W+2*CHK_W){1'b0}};
        end else if (rd_en) begin
            rd_q <= {stim_mem_q[rd_addr[AW-1:0]], exp_mem_q[rd_addr[AW-1:0]],
                     mask_mem_q[rd_addr[AW-1:0]]};
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/trace_replay_driver.sv
// Replays a preloaded stimulus trace into a DUT and checks its masked
// responses cycle by cycle, recording the first mismatching cycle.
module trace_replay_driver
    import trace_replay_pkg::*;
#(
    parameter int STIM_W       = 8,
    parameter int CHK_W        = 8,
    parameter int DEPTH        = 16,
    parameter int STOP_ON_FAIL = 1,
    parameter int CYC_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [CYC_W-1:0]      wr_addr,
    input  logic [STIM_W-1:0]     wr_stim,
    input  logic [CHK_W-1:0]      wr_exp,
    input  logic [CHK_W-1:0]      wr_mask,
    input  logic [CYC_W-1:0]      len,
    input  logic                  start,
    input  logic                  loop,
    input  logic                  abort,
    input  logic [CHK_W-1:0]      dut_out,
    output logic [STIM_W-1:0]     stim,
    output logic                  stim_valid,
    output logic [CYC_W-1:0]      cycle,
    output logic                  running,
    output logic                  done,
    output logic                  fail,
    output logic [CYC_W-1:0]      fail_cycle,
    output logic [PASS_CNT_W-1:0] pass_count
);

    state_e                  state_q;
    logic [CYC_W-1:0]        cycle_q, len_q, fail_cycle_q;
    logic                    loop_q, running_q, stim_valid_q, done_q, fail_q;
    logic [PASS_CNT_W-1:0]   pass_count_q;

    logic [CYC_W-1:0]          len_clamped_s, last_cycle_s, rd_addr_s;
    logic                      rd_en_s, mismatch_s, stop_s, wr_ok_s;
    logic [STIM_W+2*CHK_W-1:0] rd_data_s;
    logic [STIM_W-1:0]         rd_stim_s;
    logic [CHK_W-1:0]          rd_exp_s, rd_mask_s;

    assign {rd_stim_s, rd_exp_s, rd_mask_s} = rd_data_s;
    assign len_clamped_s = CYC_W'(clamp_len(32'(len), 32'(DEPTH)));
    assign last_cycle_s  = len_q - CYC_W'(1);
    assign mismatch_s    = |((dut_out ^ rd_exp_s) & rd_mask_s);
    assign stop_s        = (STOP_ON_FAIL != 0) && mismatch_s;
    assign wr_ok_s       = wr_en && (state_q != RUN);

    // The read address is the next trace cycle, so stim/exp/mask land together.
    always_comb begin
        rd_en_s   = 1'b0;
        rd_addr_s = {CYC_W{1'b0}};
        if (reset || abort) begin
            rd_en_s = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (stop_s) begin
                        rd_en_s = 1'b0;
                    end else if (cycle_q != last_cycle_s) begin
                        rd_en_s   = 1'b1;
                        rd_addr_s = cycle_q + CYC_W'(1);
                    end else begin
                        rd_en_s = loop_q;
                    end
                end
                IDLE, DONE, FAIL: begin
                    rd_en_s = start && (len_clamped_s != {CYC_W{1'b0}});
                end
                default: rd_en_s = 1'b0;
            endcase
        end
    end

    // Control FSM with all status outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cycle_q      <= {CYC_W{1'b0}};
            len_q        <= {CYC_W{1'b0}};
            loop_q       <= 1'b0;
            running_q    <= 1'b0;
            stim_valid_q <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_cycle_q <= {CYC_W{1'b0}};
            pass_count_q <= {PASS_CNT_W{1'b0}};
        end else if (abort) begin
            state_q      <= IDLE;
            running_q    <= 1'b0;
            stim_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mismatch_s && !fail_q) begin
                        fail_q       <= 1'b1;
                        fail_cycle_q <= cycle_q;
                    end
                    if (stop_s) begin
                        state_q      <= FAIL;
                        running_q    <= 1'b0;
                        stim_valid_q <= 1'b0;
                    end else if (cycle_q != last_cycle_s) begin
                        cycle_q <= cycle_q + CYC_W'(1);
                    end else if (loop_q) begin
                        cycle_q <= {CYC_W{1'b0}};
                        if (pass_count_q != {PASS_CNT_W{1'b1}}) begin
                            pass_count_q <= pass_count_q + PASS_CNT_W'(1);
                        end
                    end else begin
                        state_q      <= DONE;
                        running_q    <= 1'b0;
                        stim_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                        pass_count_q <= PASS_CNT_W'(1);
                    end
                end
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        len_q        <= len_clamped_s;
                        loop_q       <= loop;
                        cycle_q      <= {CYC_W{1'b0}};
                        fail_q       <= 1'b0;
                        fail_cycle_q <= {CYC_W{1'b0}};
                        if (len_clamped_s == {CYC_W{1'b0}}) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= RUN;
                            running_q    <= 1'b1;
                            stim_valid_q <= 1'b1;
                            done_q       <= 1'b0;
                            pass_count_q <= {PASS_CNT_W{1'b0}};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    trace_replay_mem #(
        .STIM_W (STIM_W),
        .CHK_W  (CHK_W),
        .DEPTH  (DEPTH),
        .CYC_W  (CYC_W)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_ok_s),
        .wr_addr (wr_addr),
        .wr_stim (wr_stim),
        .wr_exp  (wr_exp),
        .wr_mask (wr_mask),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    assign stim       = rd_stim_s;
    assign stim_valid = stim_valid_q;
    assign cycle      = cycle_q;
    assign running    = running_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_cycle = fail_cycle_q;
    assign pass_count = pass_count_q;

endmodule

// File: tb/tb_trace_replay_driver.sv
// Scoreboard bench: two driver instances (halt-on-fail and keep-running)
// replay a shared trace into an out = stim + 1 DUT model.
module tb_trace_replay_driver;

    localparam int STIM_W = 8;
    localparam int CHK_W  = 8;
    localparam int DEPTH  = 16;
    localparam int CYC_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CYC_W-1:0]  cyc;
        logic [STIM_W-1:0] stim;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset, wr_en, start, loop, abort;
    logic [CYC_W-1:0]  wr_addr, len;
    logic [STIM_W-1:0] wr_stim;
    logic [CHK_W-1:0]  wr_exp, wr_mask;

    logic [STIM_W-1:0] a_stim, b_stim;
    logic [CHK_W-1:0]  a_dut_out, b_dut_out;
    logic              a_stim_valid, a_running, a_done, a_fail;
    logic              b_stim_valid, b_running, b_done, b_fail;
    logic [CYC_W-1:0]  a_cycle, a_fail_cycle, b_cycle, b_fail_cycle;
    logic [15:0]       a_pass_count, b_pass_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t qa[$];
    exp_t qb[$];

    assign a_dut_out = a_stim + 8'd1;
    assign b_dut_out = b_stim + 8'd1;

    always #5 clock = ~clock;

    trace_replay_driver #(.STIM_W(STIM_W), .CHK_W(CHK_W), .DEPTH(DEPTH), .STOP_ON_FAIL(1)) dut_a (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_stim(wr_stim),
        .wr_exp(wr_exp), .wr_mask(wr_mask), .len(len), .start(start), .loop(loop),
        .abort(abort), .dut_out(a_dut_out), .stim(a_stim), .stim_valid(a_stim_valid),
        .cycle(a_cycle), .running(a_running), .done(a_done), .fail(a_fail),
        .fail_cycle(a_fail_cycle), .pass_count(a_pass_count)
    );

    trace_replay_driver #(.STIM_W(STIM_W), .CHK_W(CHK_W), .DEPTH(DEPTH), .STOP_ON_FAIL(0)) dut_b (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_stim(wr_stim),
        .wr_exp(wr_exp), .wr_mask(wr_mask), .len(len), .start(start), .loop(loop),
        .abort(abort), .dut_out(b_dut_out), .stim(b_stim), .stim_valid(b_stim_valid),
        .cycle(b_cycle), .running(b_running), .done(b_done), .fail(b_fail),
        .fail_cycle(b_fail_cycle), .pass_count(b_pass_count)
    );

    task automatic write_word(input int addr, input logic [7:0] s, input logic [7:0] e,
                              input logic [7:0] m);
        @(negedge clock);
        wr_en = 1'b1; wr_addr = CYC_W'(addr); wr_stim = s; wr_exp = e; wr_mask = m;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    // Returns at the negedge after the start edge, when cycle 0 is on stim.
    task automatic start_run(input int l, input logic lp);
        @(negedge clock);
        len = CYC_W'(l); loop = lp; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; wr_en = 1'b0; start = 1'b0; loop = 1'b0; abort = 1'b0;
        wr_addr = '0; len = '0; wr_stim = 8'h00; wr_exp = 8'h00; wr_mask = 8'h00;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({a_stim, a_stim_valid, a_cycle, a_running, a_done, a_fail, a_fail_cycle, a_pass_count} !== '0)
            $display("FAIL reset_outputs: got stim=%0h valid=%0b cyc=%0d run=%0b done=%0b fail=%0b fc=%0d pc=%0d, expected all 0",
                     a_stim, a_stim_valid, a_cycle, a_running, a_done, a_fail, a_fail_cycle, a_pass_count);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_word(i, 8'(i), 8'(i + 1), 8'hFF);
    endtask

    task automatic test_basic;
        exp_t e;
        for (int i = 0; i < 3; i++) qa.push_back('{cyc: CYC_W'(i), stim: 8'(i)});
        start_run(3, 1'b0);
        wr_en = 1'b1; wr_addr = CYC_W'(2); wr_stim = 8'h77; wr_exp = 8'h00; wr_mask = 8'hFF;
        for (int c = 0; c < 20; c++) begin
            if (!a_stim_valid) break;
            n_checks++;
            if (qa.size() == 0) begin
                $display("FAIL basic_extra: got stim=%0h, expected no further cycles", a_stim);
            end else begin
                e = qa.pop_front();
                if ({a_stim, a_running, a_cycle} !== {e.stim, 1'b1, e.cyc})
                    $display("FAIL basic_stim: got stim=%0h run=%0b cyc=%0d, expected stim=%0h run=1 cyc=%0d",
                             a_stim, a_running, a_cycle, e.stim, e.cyc);
                else n_pass++;
            end
            @(negedge clock);
            wr_en = 1'b0;
        end
        n_checks++;
        if ({qa.size() == 0, a_done, a_fail, a_running, a_pass_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd1})
            $display("FAIL basic_end: got left=%0d done=%0b fail=%0b run=%0b pc=%0d, expected left=0 done=1 fail=0 run=0 pc=1",
                     qa.size(), a_done, a_fail, a_running, a_pass_count);
        else n_pass++;
        qa.delete();
    endtask

    task automatic test_mismatch;
        exp_t e;
        write_word(1, 8'h01, 8'h00, 8'hFF);
        for (int i = 0; i < 2; i++) qa.push_back('{cyc: CYC_W'(i), stim: 8'(i)});
        for (int i = 0; i < 3; i++) qb.push_back('{cyc: CYC_W'(i), stim: 8'(i)});
        start_run(3, 1'b0);
        for (int c = 0; c < 20; c++) begin
            if (!a_stim_valid && !b_stim_valid) break;
            if (a_stim_valid) begin
                n_checks++;
                if (qa.size() == 0) begin
                    $display("FAIL stop_extra: got stim=%0h cyc=%0d, expected halt after cycle 1", a_stim, a_cycle);
                end else begin
                    e = qa.pop_front();
                    if ({a_stim, a_cycle} !== {e.stim, e.cyc})
                        $display("FAIL stop_stim: got stim=%0h cyc=%0d, expected stim=%0h cyc=%0d",
                                 a_stim, a_cycle, e.stim, e.cyc);
                    else n_pass++;
                end
            end
            if (b_stim_valid) begin
                n_checks++;
                if (qb.size() == 0) begin
                    $display("FAIL cont_extra: got stim=%0h cyc=%0d, expected no further cycles", b_stim, b_cycle);
                end else begin
                    e = qb.pop_front();
                    if ({b_stim, b_cycle} !== {e.stim, e.cyc})
                        $display("FAIL cont_stim: got stim=%0h cyc=%0d, expected stim=%0h cyc=%0d",
                                 b_stim, b_cycle, e.stim, e.cyc);
                    else n_pass++;
                end
            end
            @(negedge clock);
        end
        n_checks++;
        if ({qa.size() == 0, a_fail, a_fail_cycle, a_running, a_stim_valid, a_done, a_stim} !==
            {1'b1, 1'b1, CYC_W'(1), 1'b0, 1'b0, 1'b0, 8'h01})
            $display("FAIL stop_end: got left=%0d fail=%0b fc=%0d run=%0b valid=%0b done=%0b stim=%0h, expected left=0 fail=1 fc=1 run=0 valid=0 done=0 stim=1",
                     qa.size(), a_fail, a_fail_cycle, a_running, a_stim_valid, a_done, a_stim);
        else n_pass++;
        n_checks++;
        if ({qb.size() == 0, b_fail, b_fail_cycle, b_done, b_running, b_pass_count} !==
            {1'b1, 1'b1, CYC_W'(1), 1'b1, 1'b0, 16'd1})
            $display("FAIL cont_end: got left=%0d fail=%0b fc=%0d done=%0b run=%0b pc=%0d, expected left=0 fail=1 fc=1 done=1 run=0 pc=1",
                     qb.size(), b_fail, b_fail_cycle, b_done, b_running, b_pass_count);
        else n_pass++;
        qa.delete();
        qb.delete();
        write_word(1, 8'h01, 8'h02, 8'hFF);
    endtask

    task automatic test_loop_abort;
        exp_t e;
        for (int i = 0; i < 5; i++) qa.push_back('{cyc: CYC_W'(i % 2), stim: 8'(i % 2)});
        start_run(2, 1'b1);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            e = qa.pop_front();
            if ({a_stim, a_running, a_stim_valid, a_cycle} !== {e.stim, 1'b1, 1'b1, e.cyc})
                $display("FAIL loop_stim: got stim=%0h run=%0b valid=%0b cyc=%0d, expected stim=%0h run=1 valid=1 cyc=%0d",
                         a_stim, a_running, a_stim_valid, a_cycle, e.stim, e.cyc);
            else n_pass++;
            if (c == 4) abort = 1'b1;
            @(negedge clock);
        end
        abort = 1'b0;
        n_checks++;
        if ({a_running, a_stim_valid, a_done, a_fail, a_pass_count} !== {1'b0, 1'b0, 1'b0, 1'b0, 16'd2})
            $display("FAIL loop_abort: got run=%0b valid=%0b done=%0b fail=%0b pc=%0d, expected run=0 valid=0 done=0 fail=0 pc=2",
                     a_running, a_stim_valid, a_done, a_fail, a_pass_count);
        else n_pass++;
    endtask

    task automatic test_len_zero;
        start_run(0, 1'b0);
        n_checks++;
        if ({a_done, a_stim_valid, a_running, a_cycle, a_fail} !== {1'b1, 1'b0, 1'b0, CYC_W'(0), 1'b0})
            $display("FAIL len_zero: got done=%0b valid=%0b run=%0b cyc=%0d fail=%0b, expected done=1 valid=0 run=0 cyc=0 fail=0",
                     a_done, a_stim_valid, a_running, a_cycle, a_fail);
        else n_pass++;
    endtask

    task automatic test_len_clamp;
        exp_t e;
        write_word(16, 8'hEE, 8'h00, 8'hFF);
        for (int i = 0; i < DEPTH; i++) qa.push_back('{cyc: CYC_W'(i), stim: 8'(i)});
        start_run(20, 1'b0);
        for (int c = 0; c < 40; c++) begin
            if (!a_stim_valid) break;
            n_checks++;
            if (qa.size() == 0) begin
                $display("FAIL clamp_extra: got stim=%0h cyc=%0d, expected 16 cycles only", a_stim, a_cycle);
            end else begin
                e = qa.pop_front();
                if ({a_stim, a_cycle} !== {e.stim, e.cyc})
                    $display("FAIL clamp_stim: got stim=%0h cyc=%0d, expected stim=%0h cyc=%0d",
                             a_stim, a_cycle, e.stim, e.cyc);
                else n_pass++;
            end
            @(negedge clock);
        end
        n_checks++;
        if ({qa.size() == 0, a_done, a_fail, a_pass_count, a_cycle} !== {1'b1, 1'b1, 1'b0, 16'd1, CYC_W'(15)})
            $display("FAIL clamp_end: got left=%0d done=%0b fail=%0b pc=%0d cyc=%0d, expected left=0 done=1 fail=0 pc=1 cyc=15",
                     qa.size(), a_done, a_fail, a_pass_count, a_cycle);
        else n_pass++;
        qa.delete();
    endtask

    task automatic test_reset_mid_run;
        write_word(0, 8'hA5, 8'hA6, 8'hFF);
        start_run(3, 1'b0);
        n_checks++;
        if ({a_stim, a_cycle, a_running} !== {8'hA5, CYC_W'(0), 1'b1})
            $display("FAIL rst_first: got stim=%0h cyc=%0d run=%0b, expected stim=a5 cyc=0 run=1",
                     a_stim, a_cycle, a_running);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if ({a_stim, a_stim_valid, a_cycle, a_running, a_done, a_fail, a_fail_cycle, a_pass_count,
             b_stim, b_stim_valid, b_running, b_pass_count} !== '0)
            $display("FAIL rst_mid_run: got a_stim=%0h a_valid=%0b a_cyc=%0d a_run=%0b a_done=%0b a_pc=%0d b_stim=%0h b_run=%0b, expected all 0",
                     a_stim, a_stim_valid, a_cycle, a_running, a_done, a_pass_count, b_stim, b_running);
        else n_pass++;
        start_run(1, 1'b0);
        n_checks++;
        if ({a_stim, a_stim_valid, a_cycle} !== {8'hA5, 1'b1, CYC_W'(0)})
            $display("FAIL rst_mem_kept: got stim=%0h valid=%0b cyc=%0d, expected stim=a5 valid=1 cyc=0",
                     a_stim, a_stim_valid, a_cycle);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if ({a_done, a_fail, a_pass_count, a_stim} !== {1'b1, 1'b0, 16'd1, 8'hA5})
            $display("FAIL rst_len1_end: got done=%0b fail=%0b pc=%0d stim=%0h, expected done=1 fail=0 pc=1 stim=a5",
                     a_done, a_fail, a_pass_count, a_stim);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_loop_abort();
        test_len_zero();
        test_len_clamp();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
